// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: multi-cycle signed multiply / divide controller.
// Sign-magnitude front end. Multiply uses WIDTH_B shift-add steps. Divide uses
// WIDTH_A restoring steps. The sign is applied in the DONE cycle, which also
// emits a one-cycle ready pulse.
// Optional build macro: MULTDIV_EARLY_TERM_EN. When it is defined, a multiply
// finishes as soon as the remaining multiplier bits are all zero.
module multdiv_sequencer #(
    parameter int WIDTH_A = 32,
    parameter int WIDTH_B = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_MULT,
    input  logic               ctrl_DIV,
    input  logic [WIDTH_A-1:0] data_operandA,
    input  logic [WIDTH_B-1:0] data_operandB,
    output logic [WIDTH_A-1:0] data_result,
    output logic               data_exception,
    output logic               data_resultRDY,
    output logic               busy
);

    localparam int PW = WIDTH_A + WIDTH_B;
    localparam int CW = $clog2(WIDTH_A + 1);
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_MULT = CW'(WIDTH_B);
    localparam logic [CW-1:0]      CNT_DIV  = CW'(WIDTH_A);
    localparam logic [WIDTH_A-1:0] ONE_A    = {{(WIDTH_A-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_B-1:0] ONE_B    = {{(WIDTH_B-1){1'b0}}, 1'b1};
    // 2^(WIDTH_A-1): the largest magnitude a negative result may have
    localparam logic [PW-1:0]      MAG_LIM  = {{WIDTH_B{1'b0}}, 1'b1, {(WIDTH_A-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_MULT, ST_DIV, ST_DONE} state_e;

    function automatic logic [WIDTH_A-1:0] abs_a(input logic [WIDTH_A-1:0] x);
        return x[WIDTH_A-1] ? (~x + ONE_A) : x;
    endfunction

    function automatic logic [WIDTH_B-1:0] abs_b(input logic [WIDTH_B-1:0] x);
        return x[WIDTH_B-1] ? (~x + ONE_B) : x;
    endfunction

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic               sign_q;
    logic               is_mult_q;
    logic               exc_pend_q;
    logic [PW-1:0]      acc_q;
    logic [PW-1:0]      mcand_q;
    logic [WIDTH_B-1:0] mplier_q;
    logic [WIDTH_A-1:0] dvd_q;      // dividend shifts out at the top, quotient shifts in at the bottom
    logic [WIDTH_B-1:0] divisor_q;
    logic [WIDTH_B-1:0] rem_q;
    logic [WIDTH_A-1:0] result_q;
    logic               exc_q;
    logic               rdy_q;
    logic               busy_q;

    logic               start_s;
    logic               illegal_s;
    logic [WIDTH_A-1:0] abs_a_s;
    logic [WIDTH_B-1:0] abs_b_s;
    logic [WIDTH_B:0]   rem_sh_s;
    logic [WIDTH_B:0]   rem_diff_s;
    logic               q_bit_s;
    logic [WIDTH_B-1:0] rem_nxt_s;
    logic               mult_last_s;
    logic [PW-1:0]      mag_s;
    logic               ovf_s;
    logic               done_exc_s;
    logic [WIDTH_A-1:0] done_res_s;

    // Datapath helpers: start decode, restoring-divide step, final sign and range check
    always_comb begin
        start_s    = ctrl_MULT ^ ctrl_DIV;
        illegal_s  = ctrl_MULT & ctrl_DIV;
        abs_a_s    = abs_a(data_operandA);
        abs_b_s    = abs_b(data_operandB);
        rem_sh_s   = {rem_q, dvd_q[WIDTH_A-1]};
        rem_diff_s = rem_sh_s - {1'b0, divisor_q};
        // The remainder stays below the divisor, so the top bit of the difference is a clean borrow.
        q_bit_s    = ~rem_diff_s[WIDTH_B];
        if (q_bit_s) begin
            rem_nxt_s = rem_diff_s[WIDTH_B-1:0];
        end else begin
            rem_nxt_s = rem_sh_s[WIDTH_B-1:0];
        end
`ifdef MULTDIV_EARLY_TERM_EN
        mult_last_s = (mplier_q[WIDTH_B-1:1] == {(WIDTH_B-1){1'b0}}) || (cnt_q == CNT_ONE);
`else
        mult_last_s = (cnt_q == CNT_ONE);
`endif
        if (is_mult_q) begin
            mag_s = acc_q;
        end else begin
            mag_s = {{WIDTH_B{1'b0}}, dvd_q};
        end
        if (sign_q) begin
            ovf_s = (mag_s > MAG_LIM);
        end else begin
            ovf_s = (mag_s >= MAG_LIM);
        end
        done_exc_s = exc_pend_q | ovf_s;
        if (done_exc_s) begin
            done_res_s = {WIDTH_A{1'b0}};
        end else if (sign_q) begin
            done_res_s = ~mag_s[WIDTH_A-1:0] + ONE_A;
        end else begin
            done_res_s = mag_s[WIDTH_A-1:0];
        end
    end

    // Sequencer FSM: iterate, publish in DONE, and let any start (re)load the operands
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CW{1'b0}};
            sign_q     <= 1'b0;
            is_mult_q  <= 1'b0;
            exc_pend_q <= 1'b0;
            acc_q      <= {PW{1'b0}};
            mcand_q    <= {PW{1'b0}};
            mplier_q   <= {WIDTH_B{1'b0}};
            dvd_q      <= {WIDTH_A{1'b0}};
            divisor_q  <= {WIDTH_B{1'b0}};
            rem_q      <= {WIDTH_B{1'b0}};
            result_q   <= {WIDTH_A{1'b0}};
            exc_q      <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                ST_MULT: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CNT_ONE;
                    if (mult_last_s) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    rem_q <= rem_nxt_s;
                    dvd_q <= {dvd_q[WIDTH_A-2:0], q_bit_s};
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    result_q <= done_res_s;
                    exc_q    <= done_exc_s;
                    rdy_q    <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // A start in any state wins over the step above; in-flight work is abandoned.
            if (illegal_s) begin
                exc_pend_q <= 1'b1;
                busy_q     <= 1'b1;
                state_q    <= ST_DONE;
            end else if (start_s) begin
                sign_q     <= data_operandA[WIDTH_A-1] ^ data_operandB[WIDTH_B-1];
                is_mult_q  <= ctrl_MULT;
                exc_pend_q <= 1'b0;
                acc_q      <= {PW{1'b0}};
                mcand_q    <= {{WIDTH_B{1'b0}}, abs_a_s};
                mplier_q   <= abs_b_s;
                dvd_q      <= abs_a_s;
                divisor_q  <= abs_b_s;
                rem_q      <= {WIDTH_B{1'b0}};
                busy_q     <= 1'b1;
                if (ctrl_MULT) begin
                    cnt_q   <= CNT_MULT;
                    state_q <= ST_MULT;
                end else if (abs_b_s == {WIDTH_B{1'b0}}) begin
                    cnt_q      <= CNT_DIV;
                    exc_pend_q <= 1'b1;
                    state_q    <= ST_DONE;
                end else begin
                    cnt_q   <= CNT_DIV;
                    state_q <= ST_DIV;
                end
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer. Each started operation pushes its
// expected result, exception flag and RDY cycle onto a scoreboard. Every RDY
// pulse pops and compares one entry.
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] opa = 32'h0;
    logic [15:0] opb = 16'h0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    localparam longint MAXP = 64'sd2147483647;
    localparam longint MINP = -64'sd2147483648;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc  = 0;
    int   vecs = 0;
    int   errs = 0;

    multdiv_sequencer #(.WIDTH_A(32), .WIDTH_B(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: every RDY pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        exp_t e;
        if (data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL spurious_rdy: RDY at cycle %0d with nothing outstanding", cyc);
            end else begin
                e = sb.pop_front();
                vecs += 3;
                if (data_result !== e.res) begin
                    errs++;
                    $display("FAIL %s result: got %h expected %h", e.name, data_result, e.res);
                end
                if (data_exception !== e.exc) begin
                    errs++;
                    $display("FAIL %s exception: got %b expected %b", e.name, data_exception, e.exc);
                end
                if (cyc !== e.cyc) begin
                    errs++;
                    $display("FAIL %s rdy_cycle: got %0d expected %0d", e.name, cyc, e.cyc);
                end
            end
        end
    end

    function automatic void model_mult(input logic [31:0] a, input logic [15:0] b,
                                       output logic [31:0] r, output logic e, output int lat);
        longint p;
        int     ab;
        int     hb;
        p  = longint'($signed(a)) * longint'($signed(b));
        e  = (p > MAXP) || (p < MINP);
        r  = e ? 32'h0 : p[31:0];
        ab = int'($signed(b));
        if (ab < 0) ab = -ab;
        hb = -1;
        for (int i = 0; i < 17; i++) if (ab[i]) hb = i;
`ifdef MULTDIV_EARLY_TERM_EN
        lat = (ab == 0) ? 2 : hb + 2;
`else
        lat = 17;
`endif
    endfunction

    function automatic void model_div(input logic [31:0] a, input logic [15:0] b,
                                      output logic [31:0] r, output logic e, output int lat);
        longint q;
        if (b == 16'h0) begin
            r   = 32'h0;
            e   = 1'b1;
            lat = 1;
        end else begin
            q   = longint'($signed(a)) / longint'($signed(b));
            e   = (q > MAXP);
            r   = e ? 32'h0 : q[31:0];
            lat = 33;
        end
    endfunction

    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [15:0] b,
                            input bit aborts, input string nm);
        exp_t e;
        int   lat;
        @(negedge clock);
        ctrl_MULT = m;
        ctrl_DIV  = d;
        opa       = a;
        opb       = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        if (aborts && sb.size() > 0) void'(sb.pop_back());
        if (m && d) begin
            e.res = 32'h0;
            e.exc = 1'b1;
            lat   = 1;
        end else if (m) begin
            model_mult(a, b, e.res, e.exc, lat);
        end else begin
            model_div(a, b, e.res, e.exc, lat);
        end
        e.cyc  = cyc + lat;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            vecs++;
            errs++;
            $display("FAIL timeout: %0d results still outstanding after %0d cycles", sb.size(), n);
            sb.delete();
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        #2;
        vecs += 4;
        if (data_result !== 32'h0)    begin errs++; $display("FAIL reset_result: got %h expected 0", data_result); end
        if (data_exception !== 1'b0)  begin errs++; $display("FAIL reset_exc: got %b expected 0", data_exception); end
        if (data_resultRDY !== 1'b0)  begin errs++; $display("FAIL reset_rdy: got %b expected 0", data_resultRDY); end
        if (busy !== 1'b0)            begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_mult();
        start_op(1'b1, 1'b0, 32'd7, 16'hFFFD, 1'b0, "mult_7_m3");
        @(negedge clock);
        vecs++;
        if (busy !== 1'b1) begin errs++; $display("FAIL mult_busy: got %b expected 1", busy); end
        wait_drain();
        vecs++;
        if (busy !== 1'b0) begin errs++; $display("FAIL mult_idle: got %b expected 0", busy); end
        start_op(1'b1, 1'b0, 32'hFFFFFFFB, 16'hFFFA, 1'b0, "mult_m5_m6");        wait_drain();
        start_op(1'b1, 1'b0, 32'h7FFFFFFF, 16'h0002, 1'b0, "mult_ovf");          wait_drain();
        start_op(1'b1, 1'b0, 32'hFFFF0000, 16'h8000, 1'b0, "mult_pos_2p31");     wait_drain();
        start_op(1'b1, 1'b0, 32'h00010000, 16'h8000, 1'b0, "mult_neg_2p31");     wait_drain();
        start_op(1'b1, 1'b0, 32'h12345678, 16'h0000, 1'b0, "mult_by_zero");      wait_drain();
    endtask

    task automatic test_div();
        start_op(1'b0, 1'b1, 32'hFFFFFF9C, 16'd7,   1'b0, "div_m100_7");         wait_drain();
        start_op(1'b0, 1'b1, 32'h80000000, 16'hFFFF, 1'b0, "div_ovf");           wait_drain();
        start_op(1'b0, 1'b1, 32'h80000000, 16'h0001, 1'b0, "div_min_by_1");      wait_drain();
        start_op(1'b0, 1'b1, 32'd5,        16'h0000, 1'b0, "div_by_zero");       wait_drain();
        start_op(1'b0, 1'b1, 32'd1000,     16'h8000, 1'b0, "div_by_min");        wait_drain();
    endtask

    task automatic test_illegal();
        start_op(1'b1, 1'b1, 32'd9, 16'd3, 1'b0, "illegal_both");
        wait_drain();
    endtask

    task automatic test_abort();
        start_op(1'b1, 1'b0, 32'd3, 16'd4, 1'b0, "abort_first");
        repeat (4) @(posedge clock);
        start_op(1'b1, 1'b0, 32'd5, 16'd6, 1'b1, "abort_restart");
        wait_drain();
    endtask

    task automatic test_back_to_back();
        start_op(1'b0, 1'b1, 32'd12345, 16'hFFF9, 1'b0, "b2b_div");
        repeat (32) @(posedge clock);
        start_op(1'b1, 1'b0, 32'hFFFFFF00, 16'd300, 1'b0, "b2b_mult");
        wait_drain();
    endtask

    task automatic test_reset_mid_op();
        start_op(1'b0, 1'b1, 32'd1000, 16'd3, 1'b0, "reset_mid_div");
        repeat (9) @(posedge clock);
        #2;
        vecs++;
        if (busy !== 1'b1) begin errs++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
        reset = 1'b0;
        #1;
        vecs += 4;
        if (data_result !== 32'h0)   begin errs++; $display("FAIL midreset_result: got %h expected 0", data_result); end
        if (data_exception !== 1'b0) begin errs++; $display("FAIL midreset_exc: got %b expected 0", data_exception); end
        if (data_resultRDY !== 1'b0) begin errs++; $display("FAIL midreset_rdy: got %b expected 0", data_resultRDY); end
        if (busy !== 1'b0)           begin errs++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        void'(sb.pop_back());
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(posedge clock);
        start_op(1'b0, 1'b1, 32'd1000, 16'd3, 1'b0, "after_reset_div");
        wait_drain();
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [15:0] b;
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = 16'($urandom);
            if (i < 5) a = {{16{a[15]}}, a[15:0]};
            if (i == 7) b = 16'h0;
            if (i % 2 == 0) start_op(1'b1, 1'b0, a, b, 1'b0, "rand_mult");
            else            start_op(1'b0, 1'b1, a, b, 1'b0, "rand_div");
            wait_drain();
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_illegal();
        test_abort();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
